// File: rtl/seg7_capture.sv
// Recovers hex digits from a scanned, active-low 7-segment display bus by
// waiting for each {anode,seg} sample to stay stable before capturing it.
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  anode,
    input  logic [6:0]  seg,
    input  logic        clear,
    output logic [31:0] digits,
    output logic [7:0]  dvalid,
    output logic [7:0]  derr,
    output logic        upd,
    output logic [2:0]  upd_idx,
    output logic        frame_done
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    // Returns {legal, nibble}; anything outside the 16 hex glyphs is illegal.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    function automatic logic one_low(input logic [7:0] a);
        logic [7:0] e;
        e = ~a;
        return (e != 8'h00) && ((e & (e - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [2:0] low_index(input logic [7:0] a);
        logic [2:0] r;
        case (a)
            8'b11111110: r = 3'd0;
            8'b11111101: r = 3'd1;
            8'b11111011: r = 3'd2;
            8'b11110111: r = 3'd3;
            8'b11101111: r = 3'd4;
            8'b11011111: r = 3'd5;
            8'b10111111: r = 3'd6;
            8'b01111111: r = 3'd7;
            default:     r = 3'd0;
        endcase
        return r;
    endfunction

    logic [14:0] held_r;
    logic [7:0]  cnt_r;
    logic [14:0] sample_s;
    logic        same_s;
    logic [7:0]  cnt_next_s;
    logic        capture_s;
    logic [4:0]  dec_s;
    logic        legal_s;
    logic [2:0]  idx_s;
    logic [7:0]  dvalid_base_s;
    logic [7:0]  dvalid_next_s;

    // Stability counter next state, capture decision and next-dvalid.
    always_comb begin
        sample_s = {anode, seg};
        same_s   = (sample_s == held_r);
        if (!same_s) begin
            cnt_next_s = 8'd1;
        end else if (cnt_r >= STABLE_MAX) begin
            cnt_next_s = STABLE_MAX;
        end else begin
            cnt_next_s = cnt_r + 8'd1;
        end
        // Only the edge that reaches the threshold captures; saturation blocks repeats.
        capture_s = (cnt_next_s == STABLE_MAX) && (cnt_r != STABLE_MAX) && one_low(anode);
        dec_s     = seg_decode(seg);
        legal_s   = dec_s[4];
        idx_s     = low_index(anode);
        // A completed frame drops dvalid on the edge after it completes.
        if (dvalid == 8'hFF) begin
            dvalid_base_s = 8'h00;
        end else begin
            dvalid_base_s = dvalid;
        end
        if (capture_s && legal_s) begin
            dvalid_next_s = dvalid_base_s | (8'h01 << idx_s);
        end else begin
            dvalid_next_s = dvalid_base_s;
        end
    end

    // All state and outputs; reset then clear take priority over capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_r     <= 15'h7FFF;
            cnt_r      <= 8'd0;
            digits     <= 32'h0000_0000;
            dvalid     <= 8'h00;
            derr       <= 8'h00;
            upd        <= 1'b0;
            upd_idx    <= 3'd0;
            frame_done <= 1'b0;
        end else if (clear) begin
            held_r     <= 15'h0000;
            cnt_r      <= 8'd0;
            digits     <= 32'h0000_0000;
            dvalid     <= 8'h00;
            derr       <= 8'h00;
            upd        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            held_r     <= sample_s;
            cnt_r      <= cnt_next_s;
            upd        <= capture_s;
            dvalid     <= dvalid_next_s;
            frame_done <= (dvalid_next_s == 8'hFF) && (dvalid != 8'hFF);
            if (capture_s) begin
                upd_idx <= idx_s;
            end else begin
                upd_idx <= upd_idx;
            end
            if (capture_s && legal_s) begin
                digits[{idx_s, 2'b00} +: 4] <= dec_s[3:0];
            end else if (capture_s) begin
                derr[idx_s] <= 1'b1;
            end else begin
                derr <= derr;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus randomized
// scan traffic compared each cycle against a run-length reference model.
module tb_seg7_capture;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  anode;
    logic [6:0]  seg;
    logic        clear;
    logic [31:0] digits;
    logic [7:0]  dvalid;
    logic [7:0]  derr;
    logic        upd;
    logic [2:0]  upd_idx;
    logic        frame_done;

    seg7_capture #(.STABLE_CYCLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .anode(anode), .seg(seg), .clear(clear),
        .digits(digits), .dvalid(dvalid), .derr(derr), .upd(upd),
        .upd_idx(upd_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_upd  = 0;
    int n_fd   = 0;

    logic [6:0]  pat [16];
    int          run;
    logic [14:0] prev;
    logic [3:0]  m_dig [8];
    logic [7:0]  m_dv, m_de;
    logic        m_upd, m_fd;
    logic [2:0]  m_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_digits();
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = m_dig[i];
        return r;
    endfunction

    // Reference: run length of identical samples; capture when the run hits N.
    task automatic model(input logic [7:0] a, input logic [6:0] s, input logic clr, input logic rn);
        int code;
        int lows;
        int idx;
        if (!rn) begin
            run = 0; prev = 15'h7FFF; m_dv = 8'h00; m_de = 8'h00;
            m_upd = 1'b0; m_fd = 1'b0; m_idx = 3'd0;
            for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
        end else if (clr) begin
            run = 0; prev = 15'h0000; m_dv = 8'h00; m_de = 8'h00;
            m_upd = 1'b0; m_fd = 1'b0;
            for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
        end else begin
            if ({a, s} == prev) run++;
            else begin run = 1; prev = {a, s}; end
            lows = 0; idx = 0;
            for (int i = 0; i < 8; i++) if (!a[i]) begin lows++; idx = i; end
            code = -1;
            for (int i = 0; i < 16; i++) if (pat[i] == s) code = i;
            m_fd = 1'b0;
            if (m_dv == 8'hFF) m_dv = 8'h00;
            m_upd = (run == N) && (lows == 1);
            if (m_upd) begin
                m_idx = idx[2:0];
                if (code >= 0) begin
                    m_dig[idx] = code[3:0];
                    m_dv[idx]  = 1'b1;
                    m_fd       = (m_dv == 8'hFF);
                end else begin
                    m_de[idx] = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic [7:0] a, input logic [6:0] s, input logic clr, input logic rn);
        anode = a; seg = s; clear = clr; rst_n = rn;
        @(posedge clk);
        model(a, s, clr, rn);
        #1;
        check("digits", digits, m_digits());
        check("dvalid", {24'h0, dvalid}, {24'h0, m_dv});
        check("derr", {24'h0, derr}, {24'h0, m_de});
        check("upd", {31'h0, upd}, {31'h0, m_upd});
        check("upd_idx", {29'h0, upd_idx}, {29'h0, m_idx});
        check("frame_done", {31'h0, frame_done}, {31'h0, m_fd});
        if (upd) n_upd++;
        if (frame_done) n_fd++;
    endtask

    initial begin
        int u0;
        int f0;
        int hold;
        logic [7:0] a;
        logic [6:0] s;
        pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        anode = 8'hFF; seg = 7'h7F; clear = 1'b0; rst_n = 1'b0;
        run = 0; prev = 15'h7FFF;

        step(8'hFF, 7'h7F, 1'b0, 1'b0);
        step(8'hFF, 7'h7F, 1'b0, 1'b0);
        check("rst_digits", digits, 32'h0);
        check("rst_flags", {dvalid, derr, 5'h0, upd_idx, 6'h0, upd, frame_done}, 32'h0);

        // Digit 2 showing 5, held four edges.
        for (int e = 1; e <= 4; e++) step(8'hFB, 7'b0100100, 1'b0, 1'b1);
        check("d026_upd", {31'h0, upd}, 32'd1);
        check("d026_idx", {29'h0, upd_idx}, 32'd2);
        check("d026_nib", {28'h0, digits[11:8]}, 32'h5);
        check("d026_dv", {24'h0, dvalid}, 32'h04);
        step(8'hFB, 7'b0100100, 1'b0, 1'b1);
        check("d026_once", {31'h0, upd}, 32'd0);

        // Three edges of one glyph, then a different glyph for four.
        u0 = n_upd;
        for (int e = 0; e < 3; e++) step(8'hFD, 7'b0010010, 1'b0, 1'b1);
        for (int e = 0; e < 4; e++) step(8'hFD, 7'b0001111, 1'b0, 1'b1);
        check("d027_cnt", n_upd - u0, 32'd1);
        check("d027_nib", {28'h0, digits[7:4]}, 32'h7);

        // Illegal glyph on digit 3.
        for (int e = 0; e < 4; e++) step(8'hF7, 7'b1111110, 1'b0, 1'b1);
        check("d028_upd", {29'h0, upd_idx, 1'b0, upd}, {29'h3, 1'b0, 1'b1});
        check("d028_err", {31'h0, derr[3]}, 32'd1);
        check("d028_dv", {31'h0, dvalid[3]}, 32'd0);
        check("d028_nib", {28'h0, digits[15:12]}, 32'h0);

        // Ghosted and blank anodes never capture.
        u0 = n_upd;
        for (int e = 0; e < 20; e++) step(8'hE7, 7'b0000001, 1'b0, 1'b1);
        for (int e = 0; e < 20; e++) step(8'hFF, 7'b0000001, 1'b0, 1'b1);
        check("d029_cnt", n_upd - u0, 32'd0);
        check("d029_nib", digits, 32'h0000_0070 | 32'h0000_0500);

        // Full scan of digits 0..7 showing their own index.
        step(8'hFF, 7'h7F, 1'b1, 1'b1);
        u0 = n_upd; f0 = n_fd;
        for (int d = 0; d < 8; d++) begin
            for (int e = 1; e <= 6; e++) begin
                step(~(8'h01 << d), pat[d], 1'b0, 1'b1);
                if (d == 7 && e == 4) check("d030_fd", {31'h0, frame_done}, 32'd1);
                if (d == 7 && e == 5) check("d030_wrap", {24'h0, dvalid}, 32'h0);
            end
        end
        check("d030_cnt", n_upd - u0, 32'd8);
        check("d030_frames", n_fd - f0, 32'd1);
        check("d030_digits", digits, 32'h7654_3210);

        // Clear on the capturing edge wins.
        step(8'hFF, 7'h7F, 1'b0, 1'b1);
        for (int e = 0; e < 3; e++) step(8'hFE, 7'b0110000, 1'b0, 1'b1);
        step(8'hFE, 7'b0110000, 1'b1, 1'b1);
        check("d031_clr", {digits[7:0], dvalid, derr, 7'h0, upd}, 32'h0);

        // Reset mid-count, then a fresh count of N edges is needed.
        u0 = n_upd;
        for (int e = 0; e < 2; e++) step(8'hBF, 7'b0001000, 1'b0, 1'b1);
        step(8'hBF, 7'b0001000, 1'b0, 1'b0);
        check("d031_rst", {dvalid, derr, 5'h0, upd_idx, 6'h0, upd, frame_done}, 32'h0);
        for (int e = 0; e < 3; e++) step(8'hBF, 7'b0001000, 1'b0, 1'b1);
        check("d031_nocap", n_upd - u0, 32'd0);
        step(8'hBF, 7'b0001000, 1'b0, 1'b1);
        check("d031_cap", {29'h0, upd_idx, 1'b0, upd}, {29'h6, 1'b0, 1'b1});

        // Randomized scan traffic with occasional glitches, clears and resets.
        for (int g = 0; g < 400; g++) begin
            case ($urandom_range(0, 9))
                7:       a = 8'hFF;
                8, 9:    a = 8'($urandom);
                default: a = ~(8'h01 << $urandom_range(0, 7));
            endcase
            if ($urandom_range(0, 4) == 0) s = 7'($urandom);
            else s = pat[$urandom_range(0, 15)];
            hold = $urandom_range(1, 8);
            for (int e = 0; e < hold; e++)
                step(a, s, ($urandom_range(0, 199) == 0), ($urandom_range(0, 299) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical samples required before a digit is captured.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 anode  in  8  scanned digit enables, active-low, bit i selects digit i.
REQ-005 seg  in  7  segment drives, active-low, seg[6]=a .. seg[0]=g.
REQ-006 clear  in  1  synchronous clear of all captured state.
REQ-007 digits  out  32  recovered hex nibbles, digit i at [4i+3:4i].
REQ-008 dvalid  out  8  bit i = digit i captured with a legal pattern since last clear.
REQ-009 derr  out  8  sticky, bit i = illegal pattern seen on digit i since last clear.
REQ-010 upd  out  1  one-cycle pulse per capture event, legal or illegal.
REQ-011 upd_idx  out  3  digit index of current upd pulse; holds last value otherwise.
REQ-012 frame_done  out  1  one-cycle pulse when all 8 dvalid bits become set.

Function
REQ-013 Each edge, the block SHALL compare {anode,seg} with the held sample: if equal, the stable count increments, saturating at STABLE_CYCLES; if different, the count loads 1 and the held sample takes the new value.
REQ-014 A capture SHALL occur only on the edge at which the count reaches exactly STABLE_CYCLES; a held pattern SHALL NOT re-capture until it changes.
REQ-015 A capture SHALL be considered only if anode has exactly one low bit; all-high (blank) or multiple-low (ghost) samples SHALL never capture.
REQ-016 Legal seg patterns SHALL decode to nibbles: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 0001000=A, 1100000=B, 0110001=C, 1000010=D, 0110000=E, 0111000=F.
REQ-017 Legal capture: digits slot i SHALL load the nibble and dvalid[i] SHALL set.
REQ-018 Illegal capture (any other seg value, including 1111111): slot i and dvalid[i] unchanged, derr[i] SHALL set.
REQ-019 upd and upd_idx SHALL be registered and valid the cycle after the capturing edge; latency from first sampling edge of a new pattern to upd high = STABLE_CYCLES cycles.
REQ-020 frame_done SHALL pulse the cycle dvalid transitions to 8'hFF, and then dvalid SHALL clear to 0 on that same edge's successor, starting a new frame; digits and derr retained.
REQ-021 Recapture of an already-valid digit SHALL overwrite the nibble and pulse upd.
REQ-022 clear SHALL zero digits, dvalid, derr, stable count and held sample on the next edge; clear wins over a simultaneous capture, which is discarded (no upd).
REQ-023 Outputs SHALL be driven only from registers; no combinational input-to-output path.

Reset
REQ-024 With rst_n low at a rising edge: digits=0, dvalid=0, derr=0, upd=0, upd_idx=0, frame_done=0, stable count=0, held sample=all ones.
REQ-025 Reset asserted mid-count SHALL discard the pending capture; count restarts from the first edge after rst_n high.

Verification
REQ-026 anode=11111011, seg=0100100 held 4 edges -> upd=1 one cycle, upd_idx=2, digits[11:8]=5, dvalid=00000100.
REQ-027 Same pattern held 3 edges then seg changes -> no upd; new pattern held 4 edges -> single upd with new nibble.
REQ-028 anode=11110111, seg=1111110 held 4 edges -> upd=1, upd_idx=3, derr[3]=1, dvalid[3]=0, digits[15:12] unchanged.
REQ-029 anode=11100111 or 11111111 held 20 edges -> no upd, all outputs unchanged.
REQ-030 Scan digits 0..7 with values 0..7, 6 edges each -> 8 upd pulses, digits=32'h76543210, frame_done pulse after digit 7, dvalid=0 next cycle.
REQ-031 clear asserted on the 4th stable edge -> no upd, all state zero; rst_n low during count -> no capture, reset values per REQ-024.
